// File: rtl/trs_cmd_loader.sv
// TRS-80 /CMD file loader: parses HPS download bytes into RAM writes and a transfer address.
// Optional auto-start of the loaded program is enabled with macro TRS_CMD_AUTOEXEC_EN.
module trs_cmd_loader #(
  parameter logic [7:0] CMD_INDEX = 8'd2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        loader_download,
  output logic        loader_wr,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic [15:0] execute_addr,
  output logic        execute_enable,
  output logic        load_error
);

`ifdef TRS_CMD_AUTOEXEC_EN
  localparam bit AUTOEXEC = 1'b1;
`else
  localparam bit AUTOEXEC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_LEN, S_ADR_LO, S_ADR_HI, S_DATA,
    S_XFR_LO, S_XFR_HI, S_SKIP, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {P_LOAD, P_XFER, P_SKIP} path_t;

  state_t      state;
  path_t       path;
  logic        active;
  logic        act_q;
  logic        xfer_seen;
  logic [8:0]  cnt;
  logic [15:0] blk_addr;
  logic [7:0]  len_m2;

  assign active = ioctl_download && (ioctl_index == CMD_INDEX);
  assign len_m2 = ioctl_dout - 8'd2;

  // act_q resets high so a load already in progress at reset release is not picked up mid-stream.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      path            <= P_LOAD;
      act_q           <= 1'b1;
      xfer_seen       <= 1'b0;
      cnt             <= 9'd0;
      blk_addr        <= 16'd0;
      ioctl_wait      <= 1'b0;
      loader_download <= 1'b0;
      loader_wr       <= 1'b0;
      loader_addr     <= 16'd0;
      loader_data     <= 8'd0;
      execute_addr    <= 16'd0;
      execute_enable  <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      act_q           <= active;
      loader_download <= active;
      loader_wr       <= 1'b0;
      ioctl_wait      <= 1'b0;
      execute_enable  <= 1'b0;

      if (!active) begin
        if (act_q) begin
          if (AUTOEXEC && xfer_seen && state == S_DONE)
            execute_enable <= 1'b1;
          if (!(state inside {S_DONE, S_TYPE, S_IDLE}))
            load_error <= 1'b1;
        end
        state <= S_IDLE;
      end else if (!act_q) begin
        state        <= S_TYPE;
        load_error   <= 1'b0;
        xfer_seen    <= 1'b0;
        execute_addr <= 16'd0;
        cnt          <= 9'd0;
      end else if (ioctl_wr) begin
        case (state)
          S_TYPE: begin
            if (ioctl_dout >= 8'h20) begin
              state      <= S_ERR;
              load_error <= 1'b1;
            end else begin
              if (ioctl_dout == 8'h01)      path <= P_LOAD;
              else if (ioctl_dout == 8'h02) path <= P_XFER;
              else                          path <= P_SKIP;
              state <= S_LEN;
            end
          end
          S_LEN: begin
            case (path)
              P_LOAD: begin
                // LEN includes the two address bytes; zero remainder means a full 256-byte block.
                cnt   <= (len_m2 == 8'd0) ? 9'd256 : {1'b0, len_m2};
                state <= S_ADR_LO;
              end
              P_XFER: state <= S_XFR_LO;
              default: begin
                cnt   <= (ioctl_dout == 8'd0) ? 9'd256 : {1'b0, ioctl_dout};
                state <= S_SKIP;
              end
            endcase
          end
          S_ADR_LO: begin
            blk_addr[7:0] <= ioctl_dout;
            state         <= S_ADR_HI;
          end
          S_ADR_HI: begin
            blk_addr[15:8] <= ioctl_dout;
            state          <= S_DATA;
          end
          S_DATA: begin
            loader_wr   <= 1'b1;
            ioctl_wait  <= 1'b1;
            loader_addr <= blk_addr;
            loader_data <= ioctl_dout;
            blk_addr    <= blk_addr + 16'd1;
            cnt         <= cnt - 9'd1;
            if (cnt == 9'd1) state <= S_TYPE;
          end
          S_XFR_LO: begin
            execute_addr[7:0] <= ioctl_dout;
            state             <= S_XFR_HI;
          end
          S_XFR_HI: begin
            execute_addr[15:8] <= ioctl_dout;
            xfer_seen          <= 1'b1;
            state              <= S_DONE;
          end
          S_SKIP: begin
            cnt <= cnt - 9'd1;
            if (cnt == 9'd1) state <= S_TYPE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/trs_cmd_loader.md
TRS_CMD_LOADER -- requirements
Module: trs_cmd_loader

Interface
REQ-001 Parameter CMD_INDEX, default 8'd2, ioctl_index value identifying a CMD download.
REQ-002 clk_sys  in  1  system clock; all logic rising-edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ioctl_download  in  1  HPS download in progress.
REQ-005 ioctl_index  in  8  file-type index of the current download.
REQ-006 ioctl_wr  in  1  one-cycle strobe; ioctl_dout valid.
REQ-007 ioctl_dout  in  8  file byte.
REQ-008 ioctl_wait  out  1  backpressure to HPS; no new byte is sent while high.
REQ-009 loader_download  out  1  CMD load active.
REQ-010 loader_wr  out  1  one-cycle RAM write strobe.
REQ-011 loader_addr  out  16  RAM write address.
REQ-012 loader_data  out  8  RAM write data.
REQ-013 execute_addr  out  16  transfer address from the CMD file.
REQ-014 execute_enable  out  1  one-cycle start-program pulse.
REQ-015 load_error  out  1  sticky malformed-file flag.

Function
REQ-016 Active load is ioctl_download=1 and ioctl_index==CMD_INDEX; loader_download follows it with 1-cycle latency.
REQ-017 The block ignores ioctl_wr outside an active load.
REQ-018 Parser states are IDLE, TYPE, LEN, ADR_LO, ADR_HI, DATA, XFR_LO, XFR_HI, SKIP, DONE, ERR.
REQ-019 The rising edge of an active load enters TYPE and clears load_error, the xfer_seen flag and execute_addr.
REQ-020 Each byte in TYPE selects the next path:
- 0x01: load block.
- 0x02: transfer.
- 0x05 and any other value 0x00-0x1F: skip.
- Any value >= 0x20: ERR.
REQ-021 Each path, from LEN:
- Load block: LEN -> ADR_LO -> ADR_HI -> DATA.
- Transfer: LEN -> XFR_LO -> XFR_HI -> DONE.
- Skip: LEN -> SKIP; SKIP discards LEN bytes, with LEN=0 meaning 256.
REQ-022 Load-block data count = (LEN-2) mod 256, with a result of 0 meaning 256:
- LEN=0 gives 254 bytes.
- LEN=1 gives 255 bytes.
- LEN=2 gives 256 bytes.
- LEN=4 gives 2 bytes.
REQ-023 Each DATA byte drives loader_wr=1 for exactly one cycle, starting the cycle after the strobe, with loader_addr = block address + byte offset and loader_data = the byte.
REQ-024 loader_addr wraps from 0xFFFF to 0x0000.
REQ-025 ioctl_wait is high during every loader_wr cycle and is low otherwise.
REQ-026 After the last DATA byte, the parser returns to TYPE.
REQ-027 XFR_LO and XFR_HI capture execute_addr little-endian and set xfer_seen.
REQ-028 DONE ignores all further bytes.
REQ-029 ERR sets load_error, suppresses further writes, and ignores bytes until load end.
REQ-030 At the falling edge of an active load:
- If xfer_seen=1 and the state is DONE: execute_enable pulses for 1 cycle, 1 cycle after the edge.
- In all cases: the state returns to IDLE.
REQ-031 A load that ends in any state other than DONE, TYPE or IDLE sets load_error and produces no execute_enable.
REQ-032 A change of ioctl_index during an active load is treated as load end.

Reset
REQ-033 reset_n=0 asynchronously forces:
- State IDLE.
- ioctl_wait=0, loader_download=0, loader_wr=0, load_error=0, execute_enable=0.
- loader_addr=0, loader_data=0, execute_addr=0.
- All counters 0.
REQ-034 A reset asserted mid-load aborts it, and the load restarts only on the next rising edge of an active load.

Configuration
REQ-035 With macro TRS_CMD_AUTOEXEC_EN defined, execute_enable behaves per REQ-030.
REQ-036 Without TRS_CMD_AUTOEXEC_EN, execute_enable is tied 0 while execute_addr is still captured.

Verification
REQ-037 Download bytes 01 05 00 60 AA BB CC 02 02 00 60 at index 2 -> writes AA@6000, BB@6001 and CC@6002, then execute_addr=0x6000 and one execute_enable pulse after download falls (AUTOEXEC on).
REQ-038 Block with LEN=00 at address 7000 followed by 254 bytes -> 254 writes covering 7000-70FD, then the parser is back in TYPE.
REQ-039 Block at address FFFF with LEN=04 and data 11 22 -> 11@FFFF and 22@0000.
REQ-040 Stream 05 03 41 42 43 01 03 00 80 5A -> comment skipped, single write 5A@8000, no execute.
REQ-041 Stream 01 05 00 60 AA then download ends -> load_error=1 and no execute_enable.
REQ-042 Same bytes as REQ-037 but at index 1 -> no loader_wr and loader_download stays 0.
